// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Double-buffers the displayed value and optionally blanks leading zero digits.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ON_CYC     = 8,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    lz_en,
  output logic                    load_ack,
  output logic [3:0]              digit_code,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned CntMax = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned DataW  = 4 * NUM_DIGITS;

  typedef enum logic {StGap, StShow} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            gap_enter, show_enter, wrap;

  logic [DataW-1:0]      active_q, pending_q, active_next;
  logic                  pend_valid_q;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  blank_cur;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            code_q, code_d;
  logic                  lit_q, lit_d;
  logic                  ack_q, ack_d;
  logic                  fs_q, fs_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StGap;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    gap_enter  = 1'b0;
    show_enter = 1'b0;
    wrap       = 1'b0;
    unique case (state_q)
      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) begin
          state_d    = StShow;
          cnt_d      = '0;
          show_enter = 1'b1;
        end
      end
      StShow: begin
        if (cnt_q == CntW'(ON_CYC - 1)) begin
          state_d   = StGap;
          cnt_d     = '0;
          gap_enter = 1'b1;
          if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // A digit is blanked when it and every more significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (active_q[4*i +: 4] == 4'h0);
      blank_vec[i] = lz_en & zero_run & (i != 0);
    end
  end

  assign blank_cur   = blank_vec[idx_q];
  assign active_next = (wrap && pend_valid_q) ? pending_q : active_q;

  // Output logic
  always_comb begin
    an_d   = an_q;
    code_d = code_q;
    lit_d  = lit_q;
    ack_d  = wrap & pend_valid_q;
    fs_d   = wrap;
    if (show_enter) begin
      lit_d = ~blank_cur;
      an_d  = blank_cur ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end
    if (gap_enter) begin
      lit_d  = 1'b0;
      an_d   = '1;
      // Uses the post-transfer value so digit 0 of a new frame shows fresh data.
      code_d = active_next[4*idx_d +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      code_q       <= '0;
      lit_q        <= 1'b0;
      ack_q        <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      active_q <= active_next;
      if (wrap) begin
        pend_valid_q <= 1'b0;
      end
      // A load on the transfer cycle lands in pending after the old value moves out.
      if (load) begin
        pending_q    <= load_data;
        pend_valid_q <= 1'b1;
      end
      an_q   <= an_d;
      code_q <= code_d;
      lit_q  <= lit_d;
      ack_q  <= ack_d;
      fs_q   <= fs_d;
    end
  end

  assign an          = an_q;
  assign digit_code  = code_q;
  assign load_ack    = ack_q;
  assign frame_start = fs_q;
  assign seg_out     = lit_q ? seg_in : 7'h7F;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-count reference model queues expected
// outputs per cycle and a monitor compares them against the DUT.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int ON    = 8;
  localparam int GAP   = 2;
  localparam int SLOT  = ON + GAP;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   load_data = '0;
  logic          lz_en = 1'b0;
  logic          load_ack;
  logic [3:0]    digit_code;
  logic [6:0]    seg_in;
  logic [6:0]    seg_out;
  logic [ND-1:0] an;
  logic          frame_start;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .ON_CYC(ON), .GAP_CYC(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .lz_en      (lz_en),
    .load_ack   (load_ack),
    .digit_code (digit_code),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Active-low {g,f,e,d,c,b,a} hex decoder model
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  assign seg_in = hex7(digit_code);

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic [3:0]    code;
    logic          ack;
    logic          fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   mon_k = 0;

  // Reference model state: history since last reset
  bit          valid = 1'b0;
  int          k = 0;
  int          load_k[$];
  logic [15:0] load_v[$];
  bit          lz_hist[$];
  bit          lz_cur = 1'b0;

  // Value shown in frame f: the latest load captured before that frame's wrap cycle.
  function automatic logic [15:0] active_for(input int f);
    logic [15:0] v = '0;
    for (int i = 0; i < load_k.size(); i++)
      if (load_k[i] <= FRAME * f - 2) v = load_v[i];
    return v;
  endfunction

  function automatic bit ack_for(input int kk);
    if (kk == 0 || kk % FRAME != 0) return 1'b0;
    for (int i = 0; i < load_k.size(); i++)
      if (load_k[i] >= kk - FRAME - 1 && load_k[i] <= kk - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input int kk);
    exp_t        e;
    int          p, d, ph;
    logic [15:0] act, upper;
    bit          show, lz, blank, lit;
    p     = kk % FRAME;
    d     = p / SLOT;
    ph    = p % SLOT;
    act   = active_for(kk / FRAME);
    upper = act >> (4 * d);
    e.code = upper[3:0];
    show  = (ph >= GAP);
    lz    = show ? lz_hist[kk - ph + GAP - 1] : 1'b0;
    blank = lz && d != 0 && upper == 16'h0;
    lit   = show && !blank;
    e.an  = lit ? ~(ND'(1) << d) : '1;
    e.seg = lit ? hex7(e.code) : 7'h7F;
    e.ack = ack_for(kk);
    e.fs  = (kk != 0) && (kk % FRAME == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, mon_k, got, expv);
  endtask

  // Monitor: the DUT presents a new output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", 16'(an), 16'(e.an));
        check("seg_out", 16'(seg_out), 16'(e.seg));
        check("digit_code", 16'(digit_code), 16'(e.code));
        check("load_ack", 16'(load_ack), 16'(e.ack));
        check("frame_start", 16'(frame_start), 16'(e.fs));
        check("one_anode_max", 16'($countones(~an) <= 1), 16'd1);
        mon_k++;
      end
    end
  end

  task automatic cyc(input bit rst, input bit ld, input logic [15:0] v);
    @(negedge clk);
    if (valid) exp_q.push_back(model(k));
    reset     = rst;
    load      = ld;
    load_data = v;
    lz_en     = lz_cur;
    if (rst) begin
      valid = 1'b1;
      k     = 0;
      load_k.delete();
      load_v.delete();
      lz_hist.delete();
    end else if (valid) begin
      lz_hist.push_back(lz_cur);
      if (ld) begin
        load_k.push_back(k);
        load_v.push_back(v);
      end
      k++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic align(input int pos);
    for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] v;
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    // Basic display with ack after first wrap
    run(5);
    cyc(1'b0, 1'b1, 16'h1234);
    run(100);
    // Leading-zero blanking
    lz_cur = 1'b1;
    cyc(1'b0, 1'b1, 16'h0070);
    run(90);
    cyc(1'b0, 1'b1, 16'h0000);
    run(90);
    // Two loads in one frame give one ack
    align(3);
    cyc(1'b0, 1'b1, 16'hAAAA);
    align(20);
    cyc(1'b0, 1'b1, 16'hBBBB);
    run(90);
    // Load on the wrap cycle
    lz_cur = 1'b0;
    align(10);
    cyc(1'b0, 1'b1, 16'hC3C3);
    align(FRAME - 1);
    cyc(1'b0, 1'b1, 16'h5A01);
    run(100);
    // Reset during digit 2 SHOW discards pending
    align(2);
    cyc(1'b0, 1'b1, 16'h9999);
    align(2 * SLOT + 5);
    cyc(1'b1, 1'b0, 16'h0);
    run(100);
    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 59) == 0) lz_cur = ~lz_cur;
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 399) == 0) cyc(1'b1, 1'b0, 16'h0);
      else cyc(1'b0, ($urandom_range(0, 14) == 0), v);
    end
    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
